// File: rtl/meter_controller.sv
// Parking-meter time register: button edge detection and arbitration, saturating adds,
// presets, second timebase, display state/blink and iterative binary-to-BCD conversion.
module meter_controller #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MAX_TIME = 9999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_u,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_d,
    input  logic        sw_reset10,
    input  logic        sw_reset205,
    output logic [13:0] count,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic [1:0]  state,
    output logic        display_en,
    output logic        sec_tick
);

    localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
    localparam logic [13:0] MaxCount = 14'(MAX_TIME);
    localparam logic [14:0] MaxSum = {1'b0, MaxCount};

    typedef enum logic [1:0] {Expired = 2'd0, Low = 2'd1, Ok = 2'd2} disp_state_e;
    typedef enum logic {CvIdle, CvShift} cv_state_e;

    logic [3:0]      btn_prev_q;
    logic [3:0]      btn_now, req;
    logic            preset;
    logic [DivW-1:0] divider_q, divider_d;
    logic            phase_q, phase_d;
    logic            sec_parity_q, sec_parity_d;
    logic            half_tick, tick_now;
    logic [14:0]     amt, sum;
    logic [13:0]     sat;
    logic [13:0]     count_q, count_d;
    disp_state_e     state_q, state_d;
    logic            display_en_q, display_en_d;
    logic            sec_tick_q;

    assign btn_now = {btn_u, btn_l, btn_r, btn_d};
    assign req     = btn_now & ~btn_prev_q;
    assign preset  = sw_reset10 | sw_reset205;

    always_comb begin
        half_tick    = (divider_q == DivLast);
        tick_now     = half_tick & phase_q & ~preset;
        divider_d    = (preset || half_tick) ? '0 : divider_q + 1'b1;
        phase_d      = preset ? 1'b0 : (phase_q ^ half_tick);
        sec_parity_d = preset ? 1'b0 : (sec_parity_q ^ tick_now);

        // Priority u > l > r > d; losing requests are simply dropped.
        if (req[3])      amt = 15'd10;
        else if (req[2]) amt = 15'd180;
        else if (req[1]) amt = 15'd200;
        else if (req[0]) amt = 15'd550;
        else             amt = 15'd0;

        sum = {1'b0, count_q} + amt;
        sat = (sum > MaxSum) ? MaxCount : sum[13:0];
        if (tick_now && sat != 14'd0) sat = sat - 14'd1;

        if (sw_reset10)       count_d = 14'd10;
        else if (sw_reset205) count_d = 14'd205;
        else                  count_d = sat;

        if (count_d == 14'd0)        state_d = Expired;
        else if (count_d < 14'd200)  state_d = Low;
        else                         state_d = Ok;

        unique case (state_d)
            Ok:      display_en_d = 1'b1;
            Low:     display_en_d = ~phase_d;
            default: display_en_d = sec_parity_d;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev_q   <= '0;
            divider_q    <= '0;
            phase_q      <= 1'b0;
            sec_parity_q <= 1'b0;
            sec_tick_q   <= 1'b0;
            count_q      <= '0;
            state_q      <= Expired;
            display_en_q <= 1'b0;
        end else begin
            btn_prev_q   <= btn_now;
            divider_q    <= divider_d;
            phase_q      <= phase_d;
            sec_parity_q <= sec_parity_d;
            sec_tick_q   <= tick_now;
            count_q      <= count_d;
            state_q      <= state_d;
            display_en_q <= display_en_d;
        end
    end

    // Double-dabble converter. Changes are detected on count_d so bcd_valid drops in the same
    // cycle the count changes and never flags a stale bcd.
    cv_state_e   cv_state_q;
    logic [13:0] bin_q, shift_q;
    logic [15:0] scratch_q, scratch_adj;
    logic [3:0]  iter_q;
    logic [15:0] bcd_q;
    logic        bcd_valid_q;

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cv_state_q  <= CvIdle;
            bin_q       <= '0;
            shift_q     <= '0;
            scratch_q   <= '0;
            iter_q      <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b1;
        end else begin
            if (count_d != bin_q) begin
                // New value in either state: (re)start conversion, bcd holds its old value.
                bin_q       <= count_d;
                shift_q     <= count_d;
                scratch_q   <= '0;
                iter_q      <= '0;
                bcd_valid_q <= 1'b0;
                cv_state_q  <= CvShift;
            end else begin
                unique case (cv_state_q)
                    CvIdle: ;
                    CvShift: begin
                        if (iter_q != 4'd14) begin
                            {scratch_q, shift_q} <= {scratch_adj, shift_q} << 1;
                            iter_q <= iter_q + 4'd1;
                        end else begin
                            bcd_q       <= scratch_q;
                            bcd_valid_q <= 1'b1;
                            cv_state_q  <= CvIdle;
                        end
                    end
                    default: cv_state_q <= CvIdle;
                endcase
            end
        end
    end

    assign count      = count_q;
    assign state      = state_q;
    assign display_en = display_en_q;
    assign sec_tick   = sec_tick_q;
    assign bcd        = bcd_q;
    assign bcd_valid  = bcd_valid_q;

endmodule

// File: tb/tb_meter_controller.sv
// Randomized and directed bench for meter_controller against a cycle-count based
// arithmetic model of the meter (TICK_DIV=4, so one second is 8 clocks).
module tb_meter_controller;

    localparam int TickDiv = 4;
    localparam int MaxTime = 9999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_u = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_d = 1'b0;
    logic        sw_reset10 = 1'b0, sw_reset205 = 1'b0;
    logic [13:0] count;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic [1:0]  state;
    logic        display_en;
    logic        sec_tick;

    meter_controller #(
        .TICK_DIV(TickDiv),
        .MAX_TIME(MaxTime)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_u      (btn_u),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .btn_d      (btn_d),
        .sw_reset10 (sw_reset10),
        .sw_reset205(sw_reset205),
        .count      (count),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .state      (state),
        .display_en (display_en),
        .sec_tick   (sec_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Model: m_n counts clock edges since the last reset/preset; everything in the timebase
    // follows from it arithmetically.
    int       m_count = 0;
    int       m_n     = 0;
    int       m_since = 15;
    int       m_bcd   = 0;
    bit       m_tick  = 1'b0;
    bit [3:0] m_prev  = 4'b0;

    function automatic int to_bcd(input int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int exp_state(input int c);
        if (c == 0) return 0;
        if (c < 200) return 1;
        return 2;
    endfunction

    function automatic int exp_disp();
        int st;
        st = exp_state(m_count);
        if (st == 2) return 1;
        if (st == 1) return 1 - ((m_n / TickDiv) % 2);
        return (m_n / (2 * TickDiv)) % 2;
    endfunction

    task automatic check_all();
        check_eq("count", 32'(count), 32'(m_count));
        check_eq("state", 32'(state), 32'(exp_state(m_count)));
        check_eq("bcd", 32'(bcd), 32'(m_bcd));
        check_eq("bcd_valid", 32'(bcd_valid), 32'(m_since >= 15));
        check_eq("display_en", 32'(display_en), 32'(exp_disp()));
        check_eq("sec_tick", 32'(sec_tick), 32'(m_tick));
    endtask

    task automatic model_step(input logic [3:0] b, input logic r10, input logic r205);
        logic [3:0] req;
        int newc;
        int amt;
        bit tick;
        req    = b & ~m_prev;
        m_prev = b;
        tick   = 1'b0;
        if (r10 || r205) begin
            m_n  = 0;
            newc = r10 ? 10 : 205;
        end else begin
            m_n++;
            tick = (m_n % (2 * TickDiv)) == 0;
            amt  = req[3] ? 10 : req[2] ? 180 : req[1] ? 200 : req[0] ? 550 : 0;
            newc = m_count + amt;
            if (newc > MaxTime) newc = MaxTime;
            if (tick && newc > 0) newc--;
        end
        m_tick = tick;
        if (newc != m_count) begin
            m_since = 0;
        end else if (m_since < 15) begin
            m_since++;
            if (m_since == 15) m_bcd = to_bcd(newc);
        end
        m_count = newc;
    endtask

    // b = {u, l, r, d}
    task automatic step(input logic [3:0] b, input logic r10, input logic r205);
        @(negedge clk);
        check_all();
        {btn_u, btn_l, btn_r, btn_d} = b;
        sw_reset10  = r10;
        sw_reset205 = r205;
        model_step(b, r10, r205);
    endtask

    initial begin
        logic [3:0] rb;
        #23;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        model_step(4'b0000, 1'b0, 1'b0);

        repeat (20) step(4'b0000, 1'b0, 1'b0);

        // One long btn_d press, then let it count down.
        repeat (20) step(4'b0001, 1'b0, 1'b0);
        repeat (40) step(4'b0000, 1'b0, 1'b0);

        // Hold at 205, release.
        repeat (30) step(4'b0000, 1'b0, 1'b1);
        repeat (20) step(4'b0000, 1'b0, 1'b0);

        // Preset 10, then u and r together: only +10 applies.
        repeat (3) step(4'b0000, 1'b1, 1'b0);
        repeat (3) step(4'b1010, 1'b0, 1'b0);
        repeat (10) step(4'b0000, 1'b0, 1'b0);

        repeat (5) step(4'b0000, 1'b1, 1'b1);

        // Repeated +550 presses into saturation, restarting conversions on the way.
        repeat (22) begin
            repeat (2) step(4'b0001, 1'b0, 1'b0);
            repeat (2) step(4'b0000, 1'b0, 1'b0);
        end
        repeat (40) step(4'b0000, 1'b0, 1'b0);

        // Full countdown from 205 through LOW to EXPIRED.
        repeat (3) step(4'b0000, 1'b0, 1'b1);
        repeat (1700) step(4'b0000, 1'b0, 1'b0);

        rb = 4'b0000;
        repeat (2500) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
            step(rb, ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3));
        end
        repeat (20) step(4'b0000, 1'b0, 1'b0);

        @(negedge clk);
        check_all();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
